// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADR_W  = 3;
    localparam int unsigned BUB_CNT_W  = 2;
    localparam int unsigned WAIT_CNT_W = 8;
    localparam int unsigned PERF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_HALTED     = 2'd3
    } state_e;

    // Enables and bubble inserts for the pipeline registers and PC
    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
    } ctrl_t;

    localparam ctrl_t RUN_DEFAULT = '{
        en_pc:       1'b1,
        en_ifid:     1'b1,
        en_idex:     1'b1,
        en_exmem:    1'b1,
        en_memwb:    1'b1,
        flush_ifid:  1'b0,
        flush_idex:  1'b0,
        flush_exmem: 1'b0
    };

    localparam ctrl_t ALL_HOLD = '0;

    function automatic logic any_flush(input ctrl_t c);
        return c.flush_ifid | c.flush_idex | c.flush_exmem;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stage status inputs and register-control outputs of the pipeline sequencer.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADR_W-1:0]  id_rs_adr;
    logic [REG_ADR_W-1:0]  id_rt_adr;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADR_W-1:0]  ex_regwrite_adr;
    logic                  ex_regwrite;
    logic                  ex_from_main_mem;
    logic                  ex_branch_taken;
    logic                  mem_access;
    logic                  mem_ready;
    logic                  mem_is_halt;
    logic                  restart;

    logic                  en_pc;
    logic                  en_ifid;
    logic                  en_idex;
    logic                  en_exmem;
    logic                  en_memwb;
    logic                  flush_ifid;
    logic                  flush_idex;
    logic                  flush_exmem;
    logic                  halted;
    logic                  mem_err;
    logic [PERF_CNT_W-1:0] stall_cnt;
    logic [PERF_CNT_W-1:0] flush_cnt;

    // Pipeline side: reports stage status, consumes enables
    modport master (
        output id_rs_adr, id_rt_adr, id_uses_rs, id_uses_rt,
               ex_regwrite_adr, ex_regwrite, ex_from_main_mem, ex_branch_taken,
               mem_access, mem_ready, mem_is_halt, restart,
        input  en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem,
               halted, mem_err, stall_cnt, flush_cnt
    );

    // Sequencer side
    modport slave (
        input  id_rs_adr, id_rt_adr, id_uses_rs, id_uses_rt,
               ex_regwrite_adr, ex_regwrite, ex_from_main_mem, ex_branch_taken,
               mem_access, mem_ready, mem_is_halt, restart,
        output en_pc, en_ifid, en_idex, en_exmem, en_memwb,
               flush_ifid, flush_idex, flush_exmem,
               halted, mem_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load target.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADR_W-1:0] id_rs_adr,
    input  logic [REG_ADR_W-1:0] id_rt_adr,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic [REG_ADR_W-1:0] ex_regwrite_adr,
    input  logic                 ex_regwrite,
    input  logic                 ex_from_main_mem,
    output logic                 hazard_c
);

    logic rs_match_c;
    logic rt_match_c;

    // r0 is compared like any other register
    assign rs_match_c = id_uses_rs & (id_rs_adr == ex_regwrite_adr);
    assign rt_match_c = id_uses_rt & (id_rt_adr == ex_regwrite_adr);
    assign hazard_c   = ex_from_main_mem & ex_regwrite & (rs_match_c | rt_match_c);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch, memory wait, halt.
// Optional performance counters built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic      clk,
    input  logic      reset,
    pipe_ctrl_if.slave bus
);

    state_e                state_q, state_d;
    state_e                ret_state_q, ret_state_d;
    state_e                eff_state;
    logic [BUB_CNT_W-1:0]  bub_cnt_q, bub_cnt_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_CNT_W-1:0] wait_inc;
    logic                  mem_err_q, mem_err_d;
    logic                  hazard_c;
    logic                  halted_c;
    ctrl_t                 ctrl_c;
    ctrl_t                 ctrl_o;
    logic                  mem_stall_c;

    load_use_detect u_load_use_detect (
        .id_rs_adr        (bus.id_rs_adr),
        .id_rt_adr        (bus.id_rt_adr),
        .id_uses_rs       (bus.id_uses_rs),
        .id_uses_rt       (bus.id_uses_rt),
        .ex_regwrite_adr  (bus.ex_regwrite_adr),
        .ex_regwrite      (bus.ex_regwrite),
        .ex_from_main_mem (bus.ex_from_main_mem),
        .hazard_c         (hazard_c)
    );

    assign mem_stall_c = bus.mem_access & ~bus.mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            ret_state_q <= ST_RUN;
            bub_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            bub_cnt_q   <= bub_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    // The cycle that completes a memory wait behaves exactly like the state it returns to
    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        bub_cnt_d   = bub_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        ctrl_c      = RUN_DEFAULT;
        halted_c    = 1'b0;
        wait_inc    = wait_cnt_q + WAIT_CNT_W'(1);
        eff_state   = ((state_q == ST_MEM_WAIT) && bus.mem_ready) ? ret_state_q : state_q;
        state_d     = eff_state;

        case (eff_state)
            ST_RUN: begin
                if (bus.mem_is_halt) begin
                    ctrl_c.en_pc       = 1'b0;
                    ctrl_c.en_ifid     = 1'b0;
                    ctrl_c.en_idex     = 1'b0;
                    ctrl_c.en_exmem    = 1'b0;
                    ctrl_c.flush_exmem = 1'b1;
                    state_d            = ST_HALTED;
                end else if (mem_stall_c) begin
                    ctrl_c      = ALL_HOLD;
                    ret_state_d = ST_RUN;
                    wait_cnt_d  = '0;
                    state_d     = ST_MEM_WAIT;
                end else if (bus.ex_branch_taken) begin
                    // ID holds a wrong-path instruction, so no load-use stall is needed
                    ctrl_c.flush_ifid = 1'b1;
                    ctrl_c.flush_idex = 1'b1;
                end else if (hazard_c) begin
                    ctrl_c.en_pc      = 1'b0;
                    ctrl_c.en_ifid    = 1'b0;
                    ctrl_c.flush_idex = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        bub_cnt_d = BUB_CNT_W'(LOAD_BUBBLES - 1);
                        state_d   = ST_LOAD_STALL;
                    end
                end
            end

            ST_LOAD_STALL: begin
                if (mem_stall_c) begin
                    ctrl_c      = ALL_HOLD;
                    ret_state_d = ST_LOAD_STALL;
                    wait_cnt_d  = '0;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    ctrl_c.en_pc      = 1'b0;
                    ctrl_c.en_ifid    = 1'b0;
                    ctrl_c.flush_idex = 1'b1;
                    bub_cnt_d         = bub_cnt_q - BUB_CNT_W'(1);
                    if (bub_cnt_q <= BUB_CNT_W'(1)) begin
                        bub_cnt_d = '0;
                        state_d   = ST_RUN;
                    end
                end
            end

            ST_MEM_WAIT: begin
                ctrl_c     = ALL_HOLD;
                wait_cnt_d = wait_inc;
                if (wait_inc == WAIT_CNT_W'(MEM_TIMEOUT)) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_HALTED;
                end
            end

            ST_HALTED: begin
                ctrl_c   = ALL_HOLD;
                halted_c = 1'b1;
                if (bus.restart) begin
                    mem_err_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
        endcase
    end

    // Control outputs are forced inactive for as long as reset is held
    assign ctrl_o = reset ? ctrl_c : ALL_HOLD;

    assign bus.en_pc       = ctrl_o.en_pc;
    assign bus.en_ifid     = ctrl_o.en_ifid;
    assign bus.en_idex     = ctrl_o.en_idex;
    assign bus.en_exmem    = ctrl_o.en_exmem;
    assign bus.en_memwb    = ctrl_o.en_memwb;
    assign bus.flush_ifid  = ctrl_o.flush_ifid;
    assign bus.flush_idex  = ctrl_o.flush_idex;
    assign bus.flush_exmem = ctrl_o.flush_exmem;
    assign bus.halted      = reset & halted_c;
    assign bus.mem_err     = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic                  restart_acc_c;

    assign restart_acc_c = (state_q == ST_HALTED) & bus.restart;

    // Saturating counters, cleared when a restart is accepted
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (restart_acc_c) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (!ctrl_o.en_pc && (state_q != ST_HALTED) && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + PERF_CNT_W'(1);
            end
            if (any_flush(ctrl_o) && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: instance A (1 bubble, timeout 4), instance B (3 bubbles, timeout 15).
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam logic [7:0] C_RUN  = 8'b11111_000;
    localparam logic [7:0] C_BUB  = 8'b00111_010;
    localparam logic [7:0] C_HOLD = 8'b00000_000;
    localparam logic [7:0] C_BR   = 8'b11111_110;
    localparam logic [7:0] C_HALT = 8'b00001_001;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    pipe_ctrl_if ifa ();
    pipe_ctrl_if ifb ();

    pipe_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(4)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pipe_ctrl #(.LOAD_BUBBLES(3), .MEM_TIMEOUT(15)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    assign ifb.id_rs_adr        = ifa.id_rs_adr;
    assign ifb.id_rt_adr        = ifa.id_rt_adr;
    assign ifb.id_uses_rs       = ifa.id_uses_rs;
    assign ifb.id_uses_rt       = ifa.id_uses_rt;
    assign ifb.ex_regwrite_adr  = ifa.ex_regwrite_adr;
    assign ifb.ex_regwrite      = ifa.ex_regwrite;
    assign ifb.ex_from_main_mem = ifa.ex_from_main_mem;
    assign ifb.ex_branch_taken  = ifa.ex_branch_taken;
    assign ifb.mem_access       = ifa.mem_access;
    assign ifb.mem_ready        = ifa.mem_ready;
    assign ifb.mem_is_halt      = ifa.mem_is_halt;
    assign ifb.restart          = ifa.restart;

    logic [7:0] ctl_a;
    logic [7:0] ctl_b;
    assign ctl_a = {ifa.en_pc, ifa.en_ifid, ifa.en_idex, ifa.en_exmem, ifa.en_memwb,
                    ifa.flush_ifid, ifa.flush_idex, ifa.flush_exmem};
    assign ctl_b = {ifb.en_pc, ifb.en_ifid, ifb.en_idex, ifb.en_exmem, ifb.en_memwb,
                    ifb.flush_ifid, ifb.flush_idex, ifb.flush_exmem};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic idle();
        ifa.id_rs_adr        = 3'd0;
        ifa.id_rt_adr        = 3'd0;
        ifa.id_uses_rs       = 1'b0;
        ifa.id_uses_rt       = 1'b0;
        ifa.ex_regwrite_adr  = 3'd0;
        ifa.ex_regwrite      = 1'b0;
        ifa.ex_from_main_mem = 1'b0;
        ifa.ex_branch_taken  = 1'b0;
        ifa.mem_access       = 1'b0;
        ifa.mem_ready        = 1'b0;
        ifa.mem_is_halt      = 1'b0;
        ifa.restart          = 1'b0;
    endtask

    // Load to r3 in EX, ID reads rt=3 (rs=5 does not match)
    task automatic set_hazard();
        ifa.ex_from_main_mem = 1'b1;
        ifa.ex_regwrite      = 1'b1;
        ifa.ex_regwrite_adr  = 3'd3;
        ifa.id_rs_adr        = 3'd5;
        ifa.id_uses_rs       = 1'b1;
        ifa.id_rt_adr        = 3'd3;
        ifa.id_uses_rt       = 1'b1;
    endtask

    // Leaves the bench at a negedge with reset just released
    task automatic do_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        vectors++; if (ctl_a !== C_HOLD) begin miscompares++; $display("FAIL reset_ctl_a: got %b exp %b", ctl_a, C_HOLD); end
        vectors++; if (ctl_b !== C_HOLD) begin miscompares++; $display("FAIL reset_ctl_b: got %b exp %b", ctl_b, C_HOLD); end
        vectors++; if ({ifa.halted, ifa.mem_err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b exp 00", {ifa.halted, ifa.mem_err}); end
        vectors++; if ({ifa.stall_cnt, ifa.flush_cnt} !== 32'd0) begin miscompares++; $display("FAIL reset_cnts: got %h exp 0", {ifa.stall_cnt, ifa.flush_cnt}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++; if (ctl_a !== C_RUN) begin miscompares++; $display("FAIL post_reset_run: got %b exp %b", ctl_a, C_RUN); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_hazard();
        #1;
        vectors++; if (ctl_a !== C_BUB) begin miscompares++; $display("FAIL lu1_bubble: got %b exp %b", ctl_a, C_BUB); end
        @(negedge clk); idle(); #1;
        vectors++; if (ctl_a !== C_RUN) begin miscompares++; $display("FAIL lu1_after: got %b exp %b", ctl_a, C_RUN); end
        // rs-only match, then no match when the load does not write, then r0 match
        do_reset();
        set_hazard(); ifa.id_rs_adr = 3'd3; ifa.id_uses_rt = 1'b0; #1;
        vectors++; if (ctl_a !== C_BUB) begin miscompares++; $display("FAIL lu_rs_match: got %b exp %b", ctl_a, C_BUB); end
        do_reset();
        set_hazard(); ifa.ex_regwrite = 1'b0; #1;
        vectors++; if (ctl_a !== C_RUN) begin miscompares++; $display("FAIL lu_no_write: got %b exp %b", ctl_a, C_RUN); end
        set_hazard(); ifa.id_uses_rt = 1'b0; #1;
        vectors++; if (ctl_a !== C_RUN) begin miscompares++; $display("FAIL lu_unused_src: got %b exp %b", ctl_a, C_RUN); end
        set_hazard(); ifa.ex_regwrite_adr = 3'd0; ifa.id_rt_adr = 3'd0; #1;
        vectors++; if (ctl_a !== C_BUB) begin miscompares++; $display("FAIL lu_r0: got %b exp %b", ctl_a, C_BUB); end
    endtask

    // Three bubbles in B, interrupted by a 4-cycle memory stall on the third
    task automatic test_load_stall_memwait();
        logic [7:0] exp_b [0:7];
        exp_b[0] = C_BUB;  exp_b[1] = C_BUB;  exp_b[2] = C_HOLD; exp_b[3] = C_HOLD;
        exp_b[4] = C_HOLD; exp_b[5] = C_HOLD; exp_b[6] = C_BUB;  exp_b[7] = C_RUN;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            idle();
            if (c == 0) set_hazard();
            if (c >= 2 && c <= 6) ifa.mem_access = 1'b1;
            if (c == 6) ifa.mem_ready = 1'b1;
            #1;
            vectors++;
            if (ctl_b !== exp_b[c]) begin
                miscompares++;
                $display("FAIL lb3_cycle%0d: got %b exp %b", c, ctl_b, exp_b[c]);
            end
        end
    endtask

    task automatic test_branch();
        do_reset();
        set_hazard(); ifa.ex_branch_taken = 1'b1; #1;
        vectors++; if (ctl_b !== C_BR) begin miscompares++; $display("FAIL br_over_lu: got %b exp %b", ctl_b, C_BR); end
        @(negedge clk); idle(); #1;
        vectors++; if (ctl_b !== C_RUN) begin miscompares++; $display("FAIL br_no_stall: got %b exp %b", ctl_b, C_RUN); end
        // branch is ignored while B is in LOAD_STALL
        set_hazard(); #1;
        @(negedge clk); idle(); ifa.ex_branch_taken = 1'b1; #1;
        vectors++; if (ctl_b !== C_BUB) begin miscompares++; $display("FAIL br_in_stall: got %b exp %b", ctl_b, C_BUB); end
    endtask

    task automatic test_halt();
        do_reset();
        ifa.mem_is_halt = 1'b1; ifa.mem_access = 1'b1; ifa.mem_ready = 1'b0; #1;
        vectors++; if ({ctl_a, ifa.halted} !== {C_HALT, 1'b0}) begin miscompares++; $display("FAIL halt_issue: got %b exp %b", {ctl_a, ifa.halted}, {C_HALT, 1'b0}); end
        @(negedge clk); idle(); #1;
        vectors++; if ({ctl_a, ifa.halted} !== {C_HOLD, 1'b1}) begin miscompares++; $display("FAIL halted_state: got %b exp %b", {ctl_a, ifa.halted}, {C_HOLD, 1'b1}); end
        @(negedge clk); ifa.restart = 1'b1; #1;
        vectors++; if (ifa.halted !== 1'b1) begin miscompares++; $display("FAIL halt_restart_cycle: got %b exp 1", ifa.halted); end
        @(negedge clk); idle(); #1;
        vectors++; if ({ctl_a, ifa.halted} !== {C_RUN, 1'b0}) begin miscompares++; $display("FAIL halt_resumed: got %b exp %b", {ctl_a, ifa.halted}, {C_RUN, 1'b0}); end
        ifa.restart = 1'b1; @(negedge clk); idle(); #1;
        vectors++; if ({ctl_a, ifa.halted} !== {C_RUN, 1'b0}) begin miscompares++; $display("FAIL restart_in_run: got %b exp %b", {ctl_a, ifa.halted}, {C_RUN, 1'b0}); end
    endtask

    // A times out after 4 wait cycles; B (timeout 15) keeps waiting
    task automatic test_timeout();
        do_reset();
        ifa.mem_access = 1'b1; #1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); #1;
            vectors++;
            if ({ctl_a, ifa.halted, ifa.mem_err} !== {C_HOLD, 2'b00}) begin
                miscompares++;
                $display("FAIL to_wait%0d: got %b exp %b", c, {ctl_a, ifa.halted, ifa.mem_err}, {C_HOLD, 2'b00});
            end
        end
        @(negedge clk); #1;
        vectors++; if ({ifa.halted, ifa.mem_err} !== 2'b11) begin miscompares++; $display("FAIL to_err: got %b exp 11", {ifa.halted, ifa.mem_err}); end
        vectors++; if ({ifb.halted, ifb.mem_err} !== 2'b00) begin miscompares++; $display("FAIL to_b_waiting: got %b exp 00", {ifb.halted, ifb.mem_err}); end
        @(negedge clk); idle(); ifa.restart = 1'b1; #1;
        @(negedge clk); idle(); #1;
        vectors++; if ({ctl_a, ifa.halted, ifa.mem_err} !== {C_RUN, 2'b00}) begin miscompares++; $display("FAIL to_restart: got %b exp %b", {ctl_a, ifa.halted, ifa.mem_err}, {C_RUN, 2'b00}); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_hazard(); #1;
        @(negedge clk); idle(); ifa.mem_access = 1'b1; #1;
        @(negedge clk); #1;
        vectors++; if ({ctl_a, ctl_b} !== {C_HOLD, C_HOLD}) begin miscompares++; $display("FAIL rmw_waiting: got %b exp %b", {ctl_a, ctl_b}, {C_HOLD, C_HOLD}); end
        idle(); #1;
        reset = 1'b0; #1;
        vectors++; if ({ctl_a, ctl_b, ifa.halted, ifb.halted} !== 18'd0) begin miscompares++; $display("FAIL rmw_async: got %b exp 0", {ctl_a, ctl_b, ifa.halted, ifb.halted}); end
        @(negedge clk); reset = 1'b1; #1;
        vectors++; if ({ctl_a, ctl_b} !== {C_RUN, C_RUN}) begin miscompares++; $display("FAIL rmw_release: got %b exp %b", {ctl_a, ctl_b}, {C_RUN, C_RUN}); end
        @(negedge clk); #1;
        vectors++; if ({ctl_a, ctl_b} !== {C_RUN, C_RUN}) begin miscompares++; $display("FAIL rmw_no_residual: got %b exp %b", {ctl_a, ctl_b}, {C_RUN, C_RUN}); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_load_stall_memwait();
        test_branch();
        test_halt();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
